// File: rtl/proc_serial_pkg.sv
// Shared types and helpers for the processor serial output/input path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package proc_serial_pkg;

  // Engine state: idle (no word held) or shifting a word out.
  typedef enum logic {
    PISO_IDLE  = 1'b0,
    PISO_SHIFT = 1'b1
  } piso_state_t;

  // Width of a bit counter that indexes every bit of a width-bit word.
  function automatic int piso_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Modulo-WIDTH bit counter with synchronous clear, enable and a last-bit flag.
// Latency: count updates one cycle after clr/en; last is combinational from the count.
// Backpressure: none; en simply stalls the count.
module piso_bit_counter
  import proc_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CNT_W = piso_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt;

  // Clear wins over enable so a reload on the last-bit strobe restarts at bit 0;
  // the explicit wrap keeps non-power-of-two widths modulo WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Flag the bit currently being presented as the final one of the word.
  always_comb begin
    last = (cnt == LAST_VAL);
  end

endmodule

// File: rtl/piso_shift_engine.sv
// Parallel-to-serial shift engine: takes a WIDTH-bit word by valid/ready, emits one bit per shift_en.
// Latency: first bit on ser_out 1 cycle after load acceptance; word lasts exactly WIDTH strobes.
// Backpressure: load_ready low while a word is in flight, except on the last-bit strobe (seamless reload).
module piso_shift_engine
  import proc_serial_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  piso_state_t      state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic             out_of_reset;
  logic             shifting;
  logic             last_bit;
  logic             load_acc;
  logic             cur_bit;

  // Bit position tracking lives in the counter; it restarts on every accepted load.
  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load_acc),
    .en    (shifting),
    .last  (last_bit)
  );

  // Handshake and strobe qualification; load_ready is combinational from shift_en.
  always_comb begin
    shifting   = (state == PISO_SHIFT) && shift_en;
    done       = shifting && last_bit;
    load_ready = out_of_reset && ((state == PISO_IDLE) || done);
    load_acc   = load_valid && load_ready;
  end

  // Next register value for one shift step, with ser_in filling the vacated end.
  always_comb begin
    if (MSB_FIRST) begin
      shreg_shifted = {shreg[WIDTH-2:0], ser_in};
      cur_bit       = shreg[WIDTH-1];
    end else begin
      shreg_shifted = {ser_in, shreg[WIDTH-1:1]};
      cur_bit       = shreg[0];
    end
  end

  // Serial output and status: idle level whenever no word is being presented.
  always_comb begin
    ser_valid = (state == PISO_SHIFT);
    busy      = (state == PISO_SHIFT);
    ser_out   = (state == PISO_SHIFT) ? cur_bit : IDLE_LEVEL;
  end

  // Hold load_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
    end
  end

  // Shift register: a load overrides the final shift so back-to-back words leave no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (load_acc) begin
      shreg <= load_data;
    end else if (shifting) begin
      shreg <= shreg_shifted;
    end
  end

  // State: enter SHIFT on any accepted load, return to IDLE after the last bit with no reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PISO_IDLE;
    end else if (load_acc) begin
      state <= PISO_SHIFT;
    end else if (done) begin
      state <= PISO_IDLE;
    end
  end

endmodule

// File: tb/tb_piso_shift_engine.sv
module tb_piso_shift_engine;

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_data;
  logic       shift_en;
  logic       ser_in;

  logic m_load_ready, m_ser_out, m_ser_valid, m_busy, m_done;
  logic l_load_ready, l_ser_out, l_ser_valid, l_busy, l_done;

  int n_checks = 0;
  int n_fail   = 0;

  piso_shift_engine #(
    .WIDTH      (8),
    .MSB_FIRST  (1'b1),
    .IDLE_LEVEL (1'b0)
  ) dut_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (m_load_ready),
    .load_data  (load_data),
    .shift_en   (shift_en),
    .ser_in     (ser_in),
    .ser_out    (m_ser_out),
    .ser_valid  (m_ser_valid),
    .busy       (m_busy),
    .done       (m_done)
  );

  piso_shift_engine #(
    .WIDTH      (8),
    .MSB_FIRST  (1'b0),
    .IDLE_LEVEL (1'b1)
  ) dut_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (l_load_ready),
    .load_data  (load_data),
    .shift_en   (shift_en),
    .ser_in     (ser_in),
    .ser_out    (l_ser_out),
    .ser_valid  (l_ser_valid),
    .busy       (l_busy),
    .done       (l_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; load_valid = 1'b0; load_data = 8'h00; shift_en = 1'b0; ser_in = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if ({m_ser_out, m_ser_valid, m_busy, m_done, m_load_ready} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_msb: got %b expected 00000 (ser_out,valid,busy,done,ready)",
               {m_ser_out, m_ser_valid, m_busy, m_done, m_load_ready});
    end
    n_checks++;
    if ({l_ser_out, l_ser_valid, l_busy, l_done, l_load_ready} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_lsb: got %b expected 10000 (ser_out,valid,busy,done,ready)",
               {l_ser_out, l_ser_valid, l_busy, l_done, l_load_ready});
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if ({m_load_ready, l_load_ready, m_busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected 110 (m_ready,l_ready,busy)",
               {m_load_ready, l_load_ready, m_busy});
    end
  endtask

  // Full-rate word in both bit orders; every bit checked against the loaded word.
  task automatic test_full_rate_a5();
    logic [7:0] w;
    w = 8'hA5;
    @(negedge clk);
    load_valid = 1'b1; load_data = w; shift_en = 1'b1; ser_in = 1'b0;
    #1;
    n_checks++;
    if (m_load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL a5_ready_idle: got %b expected 1", m_load_ready);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      load_valid = 1'b0;
      #1;
      n_checks++;
      if ({m_ser_out, l_ser_out, m_ser_valid, m_busy, m_done, l_done} !==
          {w[7-k], w[k], 1'b1, 1'b1, (k == 7), (k == 7)}) begin
        n_fail++;
        $display("FAIL a5_bit%0d: got %b expected %b (m_out,l_out,valid,busy,m_done,l_done)", k,
                 {m_ser_out, l_ser_out, m_ser_valid, m_busy, m_done, l_done},
                 {w[7-k], w[k], 1'b1, 1'b1, (k == 7), (k == 7)});
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if ({m_busy, m_ser_valid, m_ser_out, l_busy, l_ser_out} !== 5'b00001) begin
      n_fail++;
      $display("FAIL a5_idle_after: got %b expected 00001",
               {m_busy, m_ser_valid, m_ser_out, l_busy, l_ser_out});
    end
  endtask

  // Strobe every third cycle: bits held for 3 cycles, done on the 24th, ser_in=1 fills register.
  task automatic test_slow_strobe();
    logic [7:0] w;
    int k;
    w = 8'h81;
    @(negedge clk);
    load_valid = 1'b1; load_data = w; shift_en = 1'b0; ser_in = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      load_valid = 1'b0;
      shift_en = ((c % 3) == 2);
      #1;
      k = c / 3;
      n_checks++;
      if ({m_ser_out, l_ser_out, m_busy, m_done, l_done} !==
          {w[7-k], w[k], 1'b1, (c == 23), (c == 23)}) begin
        n_fail++;
        $display("FAIL slow_cyc%0d: got %b expected %b (m_out,l_out,busy,m_done,l_done)", c,
                 {m_ser_out, l_ser_out, m_busy, m_done, l_done},
                 {w[7-k], w[k], 1'b1, (c == 23), (c == 23)});
      end
    end
    @(negedge clk);
    shift_en = 1'b0;
    #1;
    n_checks++;
    if ({m_busy, l_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL slow_idle: got %b expected 00", {m_busy, l_busy});
    end
    n_checks++;
    if (dut_msb.shreg !== 8'hFF || dut_lsb.shreg !== 8'hFF) begin
      n_fail++;
      $display("FAIL slow_fill: got %h/%h expected ff/ff", dut_msb.shreg, dut_lsb.shreg);
    end
    ser_in = 1'b0;
  endtask

  // Two words with no gap: reload taken on the last-bit strobe.
  task automatic test_back_to_back();
    logic [7:0] w;
    int b;
    @(negedge clk);
    load_valid = 1'b1; load_data = 8'hF0; shift_en = 1'b1; ser_in = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) load_data = 8'h0F;
      if (k == 8) load_valid = 1'b0;
      #1;
      w = (k < 8) ? 8'hF0 : 8'h0F;
      b = k % 8;
      n_checks++;
      if ({m_ser_out, l_ser_out, m_ser_valid, l_ser_valid, m_done, l_done, m_load_ready} !==
          {w[7-b], w[b], 1'b1, 1'b1, (b == 7), (b == 7), (b == 7)}) begin
        n_fail++;
        $display("FAIL b2b_bit%0d: got %b expected %b (m_out,l_out,m_vld,l_vld,m_done,l_done,ready)", k,
                 {m_ser_out, l_ser_out, m_ser_valid, l_ser_valid, m_done, l_done, m_load_ready},
                 {w[7-b], w[b], 1'b1, 1'b1, (b == 7), (b == 7), (b == 7)});
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if ({m_busy, m_ser_valid, l_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_idle: got %b expected 000", {m_busy, m_ser_valid, l_busy});
    end
  endtask

  // A load offered mid-word is refused until the last-bit strobe.
  task automatic test_midword_load();
    logic [7:0] w;
    int b;
    @(negedge clk);
    load_valid = 1'b1; load_data = 8'hAA; shift_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) load_valid = 1'b0;
      if (k == 3) begin load_valid = 1'b1; load_data = 8'h55; end
      if (k == 8) load_valid = 1'b0;
      #1;
      w = (k < 8) ? 8'hAA : 8'h55;
      b = k % 8;
      n_checks++;
      if ({m_ser_out, l_ser_out, m_load_ready, l_load_ready, m_done} !==
          {w[7-b], w[b], (b == 7), (b == 7), (b == 7)}) begin
        n_fail++;
        $display("FAIL midload_bit%0d: got %b expected %b (m_out,l_out,m_ready,l_ready,done)", k,
                 {m_ser_out, l_ser_out, m_load_ready, l_load_ready, m_done},
                 {w[7-b], w[b], (b == 7), (b == 7), (b == 7)});
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (m_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midload_idle: got %b expected 0", m_busy);
    end
  endtask

  // Reset mid-word aborts at once; a fresh load then restarts from the first bit.
  task automatic test_reset_midword();
    logic [7:0] w;
    @(negedge clk);
    load_valid = 1'b1; load_data = 8'hFF; shift_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      load_valid = 1'b0;
      #1;
      n_checks++;
      if ({m_ser_out, m_busy} !== 2'b11) begin
        n_fail++;
        $display("FAIL rstmid_pre%0d: got %b expected 11", k, {m_ser_out, m_busy});
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_ser_out, m_ser_valid, m_busy, m_done, l_ser_out, l_busy, l_done} !== 7'b0000100) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b expected 0000100",
               {m_ser_out, m_ser_valid, m_busy, m_done, l_ser_out, l_busy, l_done});
    end
    @(negedge clk); #1;
    n_checks++;
    if ({m_done, l_done, m_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_hold: got %b expected 000", {m_done, l_done, m_busy});
    end
    rst_n = 1'b1;
    w = 8'h3C;
    @(negedge clk);
    load_valid = 1'b1; load_data = w;
    #1;
    n_checks++;
    if (m_load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_ready: got %b expected 1", m_load_ready);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      load_valid = 1'b0;
      #1;
      n_checks++;
      if ({m_ser_out, l_ser_out, m_done} !== {w[7-k], w[k], (k == 7)}) begin
        n_fail++;
        $display("FAIL rstmid_bit%0d: got %b expected %b (m_out,l_out,done)", k,
                 {m_ser_out, l_ser_out, m_done}, {w[7-k], w[k], (k == 7)});
      end
    end
    @(negedge clk);
    shift_en = 1'b0;
    #1;
    n_checks++;
    if ({m_busy, m_ser_out} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_idle: got %b expected 00", {m_busy, m_ser_out});
    end
  endtask

  initial begin
    test_reset();
    test_full_rate_a5();
    test_slow_strobe();
    test_back_to_back();
    test_midword_load();
    test_reset_midword();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_shift_engine.md
Name: piso_shift_engine

Overview:
- Parametrised parallel-to-serial shift engine for the microprocessor's serial output path. It is the successor to the fixed 8-bit load/shift register.
- Accepts a WIDTH-bit word through a valid/ready handshake, then shifts it out one bit per shift_en strobe, MSB-first or LSB-first.
- Back-fills vacated bits from ser_in so that engines can be chained.
- Tracks bit count, reports busy, and pulses done at the end of each word. This lets a controller sequence words without external counters.

Parameters:
- WIDTH, 8, word width in bits; legal range is 2 or more.
- MSB_FIRST, 1, 1 = shift toward MSB and present bit WIDTH-1 first; 0 = shift toward LSB and present bit 0 first.
- IDLE_LEVEL, 1'b0, value driven on ser_out while idle.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_valid  input  1  producer offers load_data.
- load_ready  output  1  engine can accept a word this cycle.
- load_data  input  WIDTH  parallel word to serialise.
- shift_en  input  1  bit-rate strobe; one bit advances per cycle in which it is high.
- ser_in  input  1  fill bit shifted into the vacated end.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out carries a data bit.
- busy  output  1  word in progress.
- done  output  1  one-cycle pulse when the last bit of a word is consumed.

Behaviour:
- Reset (asynchronous on rst_n low, released synchronously): state=IDLE, shift register=0, bit count=0, ser_out=IDLE_LEVEL, ser_valid=0, busy=0, done=0. load_ready goes to 1 on the first cycle after reset release.
- States are IDLE and SHIFT.
- Load handshake: a load is accepted when load_valid && load_ready at a clk edge.
  - On acceptance: register <= load_data, count <= 0, state <= SHIFT.
  - The first bit appears on ser_out in the following cycle, so load-to-first-bit latency is 1 cycle.
- ser_out in SHIFT is register[WIDTH-1] when MSB_FIRST, otherwise register[0].
- In IDLE, ser_out=IDLE_LEVEL and ser_valid=0. In SHIFT, ser_valid=1 and busy=1.
- Shifting happens in SHIFT when shift_en is high at a clk edge:
  - MSB_FIRST: register <= {register[WIDTH-2:0], ser_in}.
  - LSB_FIRST: register <= {ser_in, register[WIDTH-1:1]}.
  - In both cases count <= count+1.
- shift_en is ignored in IDLE. When shift_en is low in SHIFT, the register and ser_out hold.
- Counter width is $clog2(WIDTH). "Last bit" means count == WIDTH-1.
- End of word (SHIFT, last bit, shift_en=1):
  - done=1 for exactly that cycle. done is combinational and is qualified with state and count.
  - If load_valid is also 1, back-to-back reload: register <= load_data, count <= 0, state stays SHIFT, and there are no idle bits between words.
  - Otherwise state <= IDLE.
- load_ready = (state==IDLE) || (state==SHIFT && last bit && shift_en). This is a combinational path from shift_en; producers must not make load_valid depend on load_ready.
- load_valid in SHIFT outside the last-bit strobe is not accepted. The producer must hold load_data and load_valid stable until the handshake completes.
- Reset mid-word aborts immediately. No done pulse is produced and the partial word is discarded.
- A word occupies exactly WIDTH shift_en strobes. Total cycles depend only on the strobe rate.

Decomposition:
- Shared package (proc_serial_pkg):
  - typedef enum logic {PISO_IDLE, PISO_SHIFT} piso_state_t.
  - Helper function piso_cnt_w(width) returning $clog2(width).
- The deserialiser block later imports the same package.
- One natural sub-module, piso_bit_counter: a parametrised modulo-WIDTH counter with clear, enable, and a last flag. All other logic stays in piso_shift_engine.

Test Plan:
- WIDTH=8, MSB_FIRST=1, load 8'hA5, shift_en held high → ser_out sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after load; done pulses on the 8th cycle; busy=0 after.
- MSB_FIRST=0, load 8'hA5 → ser_out sequence 1,0,1,0,0,1,0,1 read LSB-first (bits 0..7), i.e. 1,0,1,0,0,1,0,1 reversed order of bit indices; check each bit index against load_data.
- shift_en asserted every 3rd cycle, load 8'h81 → each bit held for 3 cycles; done after 24 cycles; ser_in=1 leaves register 8'hFF at end.
- Back-to-back: load_valid held with 8'hF0 then 8'h0F ready on last bit → 16 contiguous bits 11110000 00001111, one done per word, ser_valid never drops.
- rst_n asserted low after 4 bits of 8'hFF → ser_out=IDLE_LEVEL, busy=0, done stays 0 asynchronously; a new load after release restarts from bit 0.
- load_valid high in mid-word (not last bit) → load_ready=0, in-flight word unchanged, new word accepted only at the last-bit strobe.
